// File: rtl/bidir_pin_responder.sv
`default_nettype none
// ============================================================================
// Module   : bidir_pin_responder
// Brief    : Far-end responder on a half-duplex tristate pin bus. Decodes
//            initiator headers, stores write data in a local register file
//            and answers reads with one driven word framed by turnaround gaps.
// Revision : 1.0 - initial release
// ============================================================================
module bidir_pin_responder #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4,
    parameter int TURN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [WIDTH-1:0]  pin,
    input  logic              strb,
    output logic              rsp_strb,
    output logic              oe,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [WIDTH-1:0]  loc_data,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              err
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_CNT_W = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TURN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_TA1   = 3'd2,
        S_DRIVE = 3'd3,
        S_TA2   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;

    logic [WIDTH-1:0]    r_regs [c_DEPTH];
    logic [ADDR_W-1:0]   r_addr;
    logic [WIDTH-1:0]    r_rsp_word;
    logic                r_wr_pulse;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_err;

    logic                w_hdr_accept;
    logic                w_hdr_rd;
    logic [ADDR_W-1:0]   w_hdr_addr;
    logic                w_wr_commit;
    logic                w_collide;
    logic                w_drive;

    // Header/data decode; strobes outside IDLE/WDATA are collisions, never headers
    assign w_hdr_accept = (r_state == S_IDLE) && strb;
    assign w_hdr_rd     = pin[WIDTH-1];
    assign w_hdr_addr   = pin[ADDR_W-1:0];
    assign w_wr_commit  = (r_state == S_WDATA) && strb;
    assign w_collide    = strb && ((r_state == S_TA1) || (r_state == S_DRIVE) ||
                                   (r_state == S_TA2));

    // Pad enable comes straight off the state register so reset releases the bus at once
    assign w_drive  = (r_state == S_DRIVE);
    assign oe       = w_drive;
    assign rsp_strb = w_drive;
    assign pin      = w_drive ? r_rsp_word : {WIDTH{1'bz}};

    assign loc_data = r_regs[loc_addr];
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign busy     = (r_state != S_IDLE);
    assign err      = r_err;

    // State and turnaround counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; counter restarts on every entry into a turnaround state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (strb) begin
                    w_state_nxt = w_hdr_rd ? S_TA1 : S_WDATA;
                    w_cnt_nxt   = '0;
                end
            end
            S_WDATA: begin
                if (strb) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TA1: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_DRIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRIVE: begin
                w_state_nxt = S_TA2;
                w_cnt_nxt   = '0;
            end
            S_TA2: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Register file; a write lands on the data edge and is visible the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[r_addr] <= pin;
        end
    end

    // Header latch, response snapshot, write notification and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_rsp_word <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_pulse <= w_wr_commit;
            if (w_hdr_accept) begin
                r_addr <= w_hdr_addr;
                // Snapshot at the header edge so later writes cannot change the reply
                if (w_hdr_rd) begin
                    r_rsp_word <= r_regs[w_hdr_addr];
                end
            end
            if (w_wr_commit) begin
                r_wr_addr <= r_addr;
            end
            if (w_collide) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
